// File: rtl/stack_pkg.sv
// Shared definitions for the stack storage/pointer core: default sizes,
// pointer width and the burst state encoding.
package stack_pkg;

    localparam int DATA_WIDTH_DEF  = 4;
    localparam int STACK_DEPTH_DEF = 16;
    localparam int SP_WIDTH        = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/stack_ptr_ctrl_if.sv
// Request/response bundle between the stack core and its client.
// The client drives the request levels and write data; the core returns
// the edge strobes, the stack pointer and the read word.
interface stack_ptr_ctrl_if #(
    parameter int DATA_WIDTH = stack_pkg::DATA_WIDTH_DEF
);
    logic                          stack_push;
    logic                          stack_pop;
    logic                          citajVise;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          push_edge;
    logic                          pop_edge;
    logic                          read_more_edge;
    logic [stack_pkg::SP_WIDTH-1:0] sp;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          data_valid;

    modport master (
        output stack_push, stack_pop, citajVise, data_in,
        input  push_edge, pop_edge, read_more_edge, sp, data_out, data_valid
    );

    modport slave (
        input  stack_push, stack_pop, citajVise, data_in,
        output push_edge, pop_edge, read_more_edge, sp, data_out, data_valid
    );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for one request level. The strobe is combinational
// so it appears in the same cycle the level rises.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_edge
);
    logic r_prev;

    // Remember last cycle's level; starts high so a level held through reset never strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_edge = i_level & ~r_prev;
endmodule

// File: rtl/stack_ptr_ctrl.sv
// Stack storage and pointer core: turns request levels into strobes, owns
// the LIFO array and the entry count, and runs the non-destructive
// top-to-bottom read-more burst.
module stack_ptr_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_edge,
    stack_ptr_ctrl_if.slave bus
);
    localparam int                  IDX_W   = $clog2(STACK_DEPTH);
    localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [STACK_DEPTH];
    state_t                r_state;
    logic [SP_WIDTH-1:0]   r_sp;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    logic [2:0]            w_req;
    logic [2:0]            w_edge;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_burst_start;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_top_idx;

    // Bit 0 push, bit 1 pop, bit 2 read-more
    assign w_req = {bus.citajVise, bus.stack_pop, bus.stack_push};

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        edge_detect u_edge (
            .clk     (clk),
            .rst     (rst_edge),
            .i_level (w_req[gi]),
            .o_edge  (w_edge[gi])
        );
    end

    assign w_full  = (r_sp == SP_FULL);
    assign w_empty = (r_sp == '0);

    // Low bits of sp address the next free slot; top entry is one below.
    // sp == STACK_DEPTH aliases slot 0 here, but pushes are blocked when full.
    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_top_idx = w_wr_idx - IDX_W'(1);

    // Burst start outranks push/pop; simultaneous push and pop cancel each other
    assign w_burst_start = w_edge[2] & ~w_empty;
    assign w_push_ok = (r_state == IDLE) & ~w_burst_start & w_edge[0] & ~w_edge[1] & ~w_full;
    assign w_pop_ok  = (r_state == IDLE) & ~w_burst_start & w_edge[1] & ~w_edge[0] & ~w_empty;

    // Storage array: written only by an accepted push, contents survive reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= bus.data_in;
        end
    end

    // Control FSM: pointer updates, pop read and the read-more burst walk
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            r_state      <= IDLE;
            r_sp         <= '0;
            r_rd_idx     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_burst_start) begin
                        r_rd_idx <= w_top_idx;
                        r_state  <= BURST;
                    end else if (w_push_ok) begin
                        r_sp <= r_sp + SP_WIDTH'(1);
                    end else if (w_pop_ok) begin
                        r_data_out   <= r_mem[w_top_idx];
                        r_data_valid <= 1'b1;
                        r_sp         <= r_sp - SP_WIDTH'(1);
                    end
                end
                BURST: begin
                    if (!bus.citajVise) begin
                        // Requester gave up: leave without presenting a word
                        r_state <= IDLE;
                    end else begin
                        r_data_out   <= r_mem[r_rd_idx];
                        r_data_valid <= 1'b1;
                        if (r_rd_idx == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx - IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.push_edge      = w_edge[0];
    assign bus.pop_edge       = w_edge[1];
    assign bus.read_more_edge = w_edge[2];
    assign bus.sp             = r_sp;
    assign bus.data_out       = r_data_out;
    assign bus.data_valid     = r_data_valid;
endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// Bench for stack_ptr_ctrl: a per-cycle vector table for strobes, pointer and
// data_valid timing, plus a word scoreboard checked whenever data_valid is high.
module tb_stack_ptr_ctrl;
    logic clk;
    logic rst_edge;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] sb_q[$];

    typedef struct {
        logic       p;
        logic       q;
        logic       r;
        logic [3:0] d;
        logic       epe;
        logic       eppe;
        logic       erme;
        logic [7:0] esp;
        logic       edv;
        logic [11:0] words;
        int         nw;
    } vec_t;

    vec_t vt[$];

    stack_ptr_ctrl_if #(.DATA_WIDTH(4)) bus ();

    stack_ptr_ctrl #(.DATA_WIDTH(4), .STACK_DEPTH(16)) dut (
        .clk      (clk),
        .rst_edge (rst_edge),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic q, input logic r, input logic [3:0] d,
                       input logic epe, input logic eppe, input logic erme,
                       input logic [7:0] esp, input logic edv,
                       input logic [11:0] w, input int nw);
        vec_t v;
        v.p = p; v.q = q; v.r = r; v.d = d;
        v.epe = epe; v.eppe = eppe; v.erme = erme;
        v.esp = esp; v.edv = edv; v.words = w; v.nw = nw;
        vt.push_back(v);
    endtask

    // Called at posedge+1: drive levels, sample strobes mid-cycle, return at next posedge+1
    task automatic run_cycle(input logic p, input logic q, input logic r, input logic [3:0] d,
                             output logic pe, output logic ppe, output logic rme);
        bus.stack_push = p;
        bus.stack_pop  = q;
        bus.citajVise  = r;
        bus.data_in    = d;
        #2;
        pe  = bus.push_edge;
        ppe = bus.pop_edge;
        rme = bus.read_more_edge;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every presented word must match the oldest expected word
    always @(negedge clk) begin
        if (rst_edge === 1'b0 && bus.data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got word %0h want no word", bus.data_out);
            end else begin
                chk("sb_word", bus.data_out, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic pe, ppe, rme;

        rst_edge       = 1'b1;
        bus.stack_push = 1'b0;
        bus.stack_pop  = 1'b0;
        bus.citajVise  = 1'b0;
        bus.data_in    = 4'h0;

        //  p  q  r  d     pe ppe rme sp dv words    nw
        add(1, 0, 0, 4'h3, 1, 0, 0, 1, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 0);
        add(1, 0, 0, 4'h7, 1, 0, 0, 2, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 2, 0, 12'h000, 0);
        add(1, 0, 0, 4'h1, 1, 0, 0, 3, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 12'h000, 0);
        add(0, 1, 0, 4'h0, 0, 1, 0, 2, 1, 12'h001, 1);
        add(0, 0, 0, 4'h0, 0, 0, 0, 2, 0, 12'h000, 0);
        add(0, 1, 0, 4'h0, 0, 1, 0, 1, 1, 12'h007, 1);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 0);
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 1, 12'h003, 1);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 12'h000, 0);
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 12'h000, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 0, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 12'h000, 0);
        add(1, 0, 0, 4'h2, 1, 0, 0, 1, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 0);
        add(1, 0, 0, 4'h5, 1, 0, 0, 2, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 2, 0, 12'h000, 0);
        add(1, 0, 0, 4'h9, 1, 0, 0, 3, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 12'h000, 0);
        add(1, 1, 0, 4'h4, 1, 1, 0, 3, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 12'h000, 0);
        add(0, 0, 1, 4'h0, 0, 0, 1, 3, 0, 12'h259, 3);
        add(0, 0, 1, 4'h0, 0, 0, 0, 3, 1, 12'h000, 0);
        add(0, 0, 1, 4'h0, 0, 0, 0, 3, 1, 12'h000, 0);
        add(0, 0, 1, 4'h0, 0, 0, 0, 3, 1, 12'h000, 0);
        add(0, 0, 1, 4'h0, 0, 0, 0, 3, 0, 12'h000, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 12'h000, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp", bus.sp, 0);
        chk("rst_dv", bus.data_valid, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_pe", bus.push_edge, 0);
        rst_edge = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            for (int k = 0; k < vt[i].nw; k++) sb_q.push_back(vt[i].words[k*4 +: 4]);
            run_cycle(vt[i].p, vt[i].q, vt[i].r, vt[i].d, pe, ppe, rme);
            chk($sformatf("row%0d_pe", i), pe, vt[i].epe);
            chk($sformatf("row%0d_ppe", i), ppe, vt[i].eppe);
            chk($sformatf("row%0d_rme", i), rme, vt[i].erme);
            chk($sformatf("row%0d_sp", i), bus.sp, vt[i].esp);
            chk($sformatf("row%0d_dv", i), bus.data_valid, vt[i].edv);
            $display("row %0d push=%b pop=%b rm=%b sp=%0d dv=%b dout=%0h",
                     i, vt[i].p, vt[i].q, vt[i].r, bus.sp, bus.data_valid, bus.data_out);
        end

        // Fill from 3 to 16 entries with mem[k] = k ^ 5
        for (int k = 3; k < 16; k++) begin
            run_cycle(1, 0, 0, 4'(k ^ 5), pe, ppe, rme);
            chk("fill_pe", pe, 1);
            run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
            chk("fill_sp", bus.sp, k + 1);
        end
        $display("fill sp=%0d", bus.sp);
        run_cycle(1, 0, 0, 4'hF, pe, ppe, rme);
        chk("full_pe", pe, 1);
        chk("full_sp", bus.sp, 16);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        sb_q.push_back(4'hA);
        run_cycle(0, 1, 0, 4'h0, pe, ppe, rme);
        chk("full_pop_ppe", ppe, 1);
        chk("full_pop_sp", bus.sp, 15);
        chk("full_pop_dv", bus.data_valid, 1);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        $display("full push refused, pop sp=%0d", bus.sp);

        // Abort after first burst word (top is mem[14] = 0xB)
        sb_q.push_back(4'hB);
        run_cycle(0, 0, 1, 4'h0, pe, ppe, rme);
        chk("abort_rme", rme, 1);
        chk("abort_dv0", bus.data_valid, 0);
        run_cycle(0, 0, 1, 4'h0, pe, ppe, rme);
        chk("abort_dv1", bus.data_valid, 1);
        chk("abort_dout", bus.data_out, 4'hB);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        chk("abort_dv2", bus.data_valid, 0);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        chk("abort_dv3", bus.data_valid, 0);
        chk("abort_sp", bus.sp, 15);
        // A pop now only executes if the FSM is back in IDLE
        sb_q.push_back(4'hB);
        run_cycle(0, 1, 0, 4'h0, pe, ppe, rme);
        chk("abort_idle_sp", bus.sp, 14);
        chk("abort_idle_dv", bus.data_valid, 1);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        $display("abort sp=%0d", bus.sp);

        // Push held high through reset release gives no strobe
        bus.stack_push = 1'b1;
        rst_edge = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_edge = 1'b0;
        #1;
        chk("hold_pe0", bus.push_edge, 0);
        @(posedge clk);
        #1;
        chk("hold_pe1", bus.push_edge, 0);
        chk("hold_sp", bus.sp, 0);
        bus.stack_push = 1'b0;
        @(posedge clk);
        #1;
        $display("push held through reset sp=%0d", bus.sp);

        // Asynchronous reset in the middle of a burst
        run_cycle(1, 0, 0, 4'h6, pe, ppe, rme);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        run_cycle(1, 0, 0, 4'h3, pe, ppe, rme);
        run_cycle(0, 0, 0, 4'h0, pe, ppe, rme);
        chk("mid_sp", bus.sp, 2);
        sb_q.push_back(4'h3);
        run_cycle(0, 0, 1, 4'h0, pe, ppe, rme);
        chk("mid_rme", rme, 1);
        run_cycle(0, 0, 1, 4'h0, pe, ppe, rme);
        chk("mid_dv", bus.data_valid, 1);
        chk("mid_dout", bus.data_out, 4'h3);
        @(negedge clk);
        #1;
        rst_edge = 1'b1;
        #1;
        chk("async_sp", bus.sp, 0);
        chk("async_dv", bus.data_valid, 0);
        chk("async_dout", bus.data_out, 0);
        @(posedge clk);
        #1;
        bus.citajVise = 1'b0;
        rst_edge = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_dv", bus.data_valid, 0);
        chk("post_sp", bus.sp, 0);
        $display("mid-burst reset sp=%0d dv=%b", bus.sp, bus.data_valid);

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
